lif_spike_aer_encoder: RTL
==========================

# lif_spike_aer_encoder

Downstream stage of the time-multiplexed LIF neuron core. Each section evaluation yields one `post_spike` decision. This block timestamps every spike with the current sample (frame) number and tags it with its section index. Events are buffered in a first-word-fall-through FIFO and leave as address-event (AER) words over a valid/ready handshake toward the spike logger or readout.

## Interface
- `N_SEC`, default 50: sections per sample frame; legal `sec_idx` range is 0..N_SEC-1.
- `FIFO_DEPTH`, default 16: event FIFO depth, power of 2, at least 4.
- `TS_W`, default 16: timestamp width in frames.
- `clk_in`  in  1  system clock.
- `reset_n`  in  1  reset: asynchronous, active-low.
- `sec_done`  in  1  one-cycle strobe; the LIF core has finished updating section `sec_idx`.
- `post_spike`  in  1  spike decision; qualified only by `sec_done`.
- `sec_idx`  in  7  section index; qualified only by `sec_done`.
- `aer_valid`  out  1  head event available.
- `aer_ready`  in  1  consumer accepts the head event.
- `aer_addr`  out  7  section index of the head event.
- `aer_ts`  out  TS_W  frame timestamp of the head event.
- `fifo_count`  out  log2(FIFO_DEPTH)+1  occupancy, 0..FIFO_DEPTH.
- `overflow`  out  1  sticky; an event was dropped.
- `drop_cnt`  out  16  dropped-event count, saturating.
- `clr_status`  in  1  synchronous clear of `overflow` and `drop_cnt`.

## Operation
- Frame counter `ts`, TS_W bits, reset 0.
  - Increments on any cycle with `sec_done` and `sec_idx == N_SEC-1`.
  - Wraps from 2^TS_W-1 to 0.
- Event candidate: `sec_done & post_spike & (sec_idx < N_SEC)`.
  - Entry stored is {`ts` before this cycle's increment, `sec_idx`}.
  - A spike on section N_SEC-1 carries the current frame's `ts`.
- `sec_done` with `sec_idx >= N_SEC`:
  - No event and no `ts` increment.
  - Not counted as a drop.
- Pop: `aer_valid & aer_ready`.
- Push/pop rules:
  - Not full: push accepted.
  - Full, no pop in the same cycle: candidate dropped. `overflow` ← 1; `drop_cnt` += 1, saturating at 0xFFFF.
  - Full with a pop in the same cycle: push accepted, `fifo_count` unchanged, no drop.
  - Empty with push: no pop is possible that cycle (`aer_valid` is 0).
- FIFO order is strict; events leave in arrival order.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by `fifo_count`, or by an extra pointer bit.
- `clr_status`:
  - Clears `overflow` and `drop_cnt` at the next edge.
  - A drop in the same cycle wins: result is `overflow`=1, `drop_cnt`=1.
- `aer_ready` while `aer_valid`=0 is ignored.

## Timing
- Reset values: `aer_valid`=0, `aer_addr`=0, `aer_ts`=0, `fifo_count`=0, `overflow`=0, `drop_cnt`=0, internal `ts`=0, both FIFO pointers 0.
- Asynchronous reset mid-operation discards all queued events.
- Latency: event candidate at edge k gives `aer_valid`=1 with the matching `aer_addr`/`aer_ts` in the cycle after edge k, when the FIFO was empty. Other outputs also update at edge k.
- All outputs are registered, or driven from registered FIFO storage and pointers. No combinational path from `aer_ready` to `aer_valid`, `aer_addr` or `aer_ts`.
- While `aer_valid`=1 and `aer_ready`=0, `aer_addr` and `aer_ts` hold stable.
- After a pop at edge k:
  - The next entry is presented after edge k.
  - If the FIFO becomes empty, `aer_valid` drops after edge k.
- Sustained throughput: one pop per cycle. Input rate is at most one event per `sec_done`, nominally one per 16 cycles.
- `fifo_count` reflects push and pop from the edge at which they occur.

## Test plan
- Reset, then `sec_done` for sections 0..49 with `post_spike`=1 at sec 3 and 49, `aer_ready`=1:
  - Events (3, ts 0) then (49, ts 0).
  - Next frame: sec 3 spike yields (3, ts 1).
- `aer_ready`=0, 16 spikes, then a 17th:
  - `fifo_count`=16; 17th dropped; `overflow`=1; `drop_cnt`=1.
  - Release `aer_ready`: 16 events in order, `aer_valid` continuous, then 0.
- FIFO full, `aer_ready`=1 and a new spike in the same cycle: no drop, `fifo_count` stays 16, new event is last out.
- Drive 2^TS_W frames: timestamp sequence ..., 0xFFFF, 0x0000; spikes stamped accordingly.
- `sec_done` with `sec_idx`=60 and `post_spike`=1: no event, `ts` unchanged, `drop_cnt` unchanged.
- `clr_status` in the same cycle as an overflow drop: `overflow`=1, `drop_cnt`=1. Assert `reset_n`=0 with 5 events queued: all outputs return to reset values at once.

Source files
------------

// File: rtl/lif_spike_aer_encoder.sv
// lif_spike_aer_encoder
// Stamps each LIF post-synaptic spike with the current frame number and its
// section index, queues it in a first-word-fall-through FIFO, and presents
// the head event as an AER word over a valid/ready handshake.
module lif_spike_aer_encoder #(
    parameter int N_SEC      = 50,
    parameter int FIFO_DEPTH = 16,
    parameter int TS_W       = 16
) (
    input  logic                          clk_in,
    input  logic                          reset_n,
    input  logic                          sec_done,
    input  logic                          post_spike,
    input  logic [6:0]                    sec_idx,
    output logic                          aer_valid,
    input  logic                          aer_ready,
    output logic [6:0]                    aer_addr,
    output logic [TS_W-1:0]               aer_ts,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [15:0]                   drop_cnt,
    input  logic                          clr_status
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = TS_W + 7;
    localparam logic [6:0]  LAST_SEC = 7'(N_SEC - 1);
    localparam logic [6:0]  NSEC_L   = 7'(N_SEC);
    localparam logic [AW:0] DEPTH_L  = (AW + 1)'(FIFO_DEPTH);

    // Event storage: {timestamp, section index} per entry
    logic [EW-1:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic [TS_W-1:0] ts_r;
    logic            overflow_r;
    logic [15:0]     drop_cnt_r;

    logic            valid_s;
    logic            full_s;
    logic            cand_s;
    logic            frame_end_s;
    logic            pop_s;
    logic            push_s;
    logic            drop_s;
    logic [EW-1:0]   head_s;

    // Handshake, push/pop/drop decisions for the current cycle
    always_comb begin
        valid_s     = 1'b0;
        full_s      = 1'b0;
        cand_s      = 1'b0;
        frame_end_s = 1'b0;
        pop_s       = 1'b0;
        push_s      = 1'b0;
        drop_s      = 1'b0;
        head_s      = mem_r[rd_ptr_r];
        valid_s     = (count_r != {(AW + 1){1'b0}});
        full_s      = (count_r == DEPTH_L);
        // Out-of-range indices neither produce events nor advance the frame
        cand_s      = sec_done & post_spike & (sec_idx < NSEC_L);
        frame_end_s = sec_done & (sec_idx == LAST_SEC);
        pop_s       = valid_s & aer_ready;
        // A full FIFO still accepts a push when the head leaves this cycle
        push_s      = cand_s & (~full_s | pop_s);
        drop_s      = cand_s & full_s & ~pop_s;
    end

    // Frame counter; the spike on the last section carries the pre-increment value
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            ts_r <= {TS_W{1'b0}};
        end else if (frame_end_s) begin
            ts_r <= ts_r + TS_W'(1);
        end else begin
            ts_r <= ts_r;
        end
    end

    // FIFO storage and pointers; reset clears entries so the head reads zero
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {EW{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {ts_r, sec_idx};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Occupancy tracks push and pop from the edge they occur on
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {(AW + 1){1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow and saturating drop count; a same-cycle drop beats the clear
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 16'h0000;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (clr_status) begin
                drop_cnt_r <= 16'h0001;
            end else if (drop_cnt_r != 16'hFFFF) begin
                drop_cnt_r <= drop_cnt_r + 16'h0001;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end else if (clr_status) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 16'h0000;
        end else begin
            overflow_r <= overflow_r;
            drop_cnt_r <= drop_cnt_r;
        end
    end

    // Outputs come straight from registered state; aer_ready never reaches them
    assign aer_valid  = valid_s;
    assign aer_addr   = valid_s ? head_s[6:0]    : 7'd0;
    assign aer_ts     = valid_s ? head_s[EW-1:7] : {TS_W{1'b0}};
    assign fifo_count = count_r;
    assign overflow   = overflow_r;
    assign drop_cnt   = drop_cnt_r;

endmodule
